// File: rtl/freq_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl_if
//
// Bundles the signals between the gate sequencer and its two neighbours. The
// neighbours are the edge counter (clear, enable, live count, overflow) and the
// display formatter (result data, overflow, valid/ready handshake).
//
// Modports:
//   master : the sequencer. It drives cnt_clr, cnt_en, res_data, res_ovf and
//            res_valid. It samples cnt_value, cnt_ovf and res_ready.
//   slave  : the counter/formatter side. It is the mirror image of master.
//
// Signals:
//   cnt_clr    synchronous clear to the edge counter
//   cnt_en     count enable (gate open)
//   cnt_value  live count from the edge counter, CNT_W bits
//   cnt_ovf    counter saturated/wrapped flag
//   res_data   captured count, CNT_W bits
//   res_ovf    captured overflow flag
//   res_valid  result available
//   res_ready  formatter accepts result
// -----------------------------------------------------------------------------
interface freq_gate_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_ovf;
    logic [CNT_W-1:0] res_data;
    logic             res_ovf;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output cnt_clr,
        output cnt_en,
        output res_data,
        output res_ovf,
        output res_valid,
        input  cnt_value,
        input  cnt_ovf,
        input  res_ready
    );

    modport slave (
        input  cnt_clr,
        input  cnt_en,
        input  res_data,
        input  res_ovf,
        input  res_valid,
        output cnt_value,
        output cnt_ovf,
        output res_ready
    );
endinterface

// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//
// Measurement sequencer for the frequency counter datapath. One measurement
// runs through these steps:
//   1. Clear the edge counter for one cycle.
//   2. Open the gate (cnt_en) for exactly GATE_CYCLES clocks.
//   3. Wait SETTLE_CYCLES clocks so that edges still in the input synchroniser
//      are counted.
//   4. Capture the count and overflow flag.
//   5. Hold the captured result on a valid/ready handshake until the display
//      formatter accepts it.
// In single-shot mode a start pulse in IDLE triggers one measurement. In
// continuous mode the block re-arms straight from the handshake into the next
// clear.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; forces IDLE and all outputs low
//   ena    block enable; dropping it in CLEAR/GATE/SETTLE aborts the
//          measurement and produces no result
//   start  single-shot trigger, only looked at in IDLE
//   cont   continuous mode, only looked at in IDLE and at PRESENT exit
//   busy   high whenever the sequencer is not IDLE
//   meas   counter + result bundle (freq_gate_ctrl_if.master)
//
// Every output is decoded from registered state or comes directly from a
// register. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module freq_gate_ctrl #(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    freq_gate_ctrl_if.master  meas
);

    // The timer has to hold the larger of the two reload values. It has one
    // spare bit so the width stays sensible when a parameter is a power of two.
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO    = '0;
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_PRESENT = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [TMR_W-1:0] timer_reg;
    logic [TMR_W-1:0] timer_next;
    logic [CNT_W-1:0] res_data_reg;
    logic             res_ovf_reg;
    logic             capture;

    // -------------------------------------------------------------------------
    // Next-state / timer logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        capture    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ena && (start || cont)) begin
                    state_next = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                if (!ena) begin
                    state_next = ST_IDLE;
                    timer_next = TMR_ZERO;
                end else begin
                    state_next = ST_GATE;
                    timer_next = GATE_LOAD;
                end
            end

            // The timer counts GATE_LOAD..0, so the gate stays open for
            // exactly GATE_CYCLES cycles. It stops at zero and never wraps.
            ST_GATE: begin
                if (!ena) begin
                    state_next = ST_IDLE;
                    timer_next = TMR_ZERO;
                end else if (timer_reg == TMR_ZERO) begin
                    state_next = ST_SETTLE;
                    timer_next = SETTLE_LOAD;
                end else begin
                    timer_next = timer_reg - TMR_ONE;
                end
            end

            // An abort takes priority over capture. If ena is low on the final
            // settle edge, no result is produced.
            ST_SETTLE: begin
                if (!ena) begin
                    state_next = ST_IDLE;
                    timer_next = TMR_ZERO;
                end else if (timer_reg == TMR_ZERO) begin
                    state_next = ST_PRESENT;
                    capture    = 1'b1;
                end else begin
                    timer_next = timer_reg - TMR_ONE;
                end
            end

            // ena is deliberately ignored here until the handshake completes.
            // A result that is already on the bus is never withdrawn.
            ST_PRESENT: begin
                if (meas.res_ready) begin
                    state_next = (ena && cont) ? ST_CLEAR : ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                timer_next = TMR_ZERO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, timer and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= TMR_ZERO;
            res_data_reg <= '0;
            res_ovf_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            // The result registers change only on capture. They keep the last
            // measurement after the handshake.
            if (capture) begin
                res_data_reg <= meas.cnt_value;
                res_ovf_reg  <= meas.cnt_ovf;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    assign meas.cnt_clr   = (state_reg == ST_CLEAR);
    assign meas.cnt_en    = (state_reg == ST_GATE);
    assign meas.res_valid = (state_reg == ST_PRESENT);
    assign meas.res_data  = res_data_reg;
    assign meas.res_ovf   = res_ovf_reg;
    assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_ctrl
//
// Self-checking bench for freq_gate_ctrl with GATE_CYCLES=10, SETTLE_CYCLES=2.
//
// Reference model: each measurement is tracked by its accept edge t0. The model
// derives the outputs from cycle arithmetic:
//   - clear in the cycle after t0
//   - gate open after edges t0+1 .. t0+GATE
//   - capture on edge t0+GATE+SETTLE+1
// Captured values are pushed into a scoreboard queue. A separate monitor
// compares each presented result against that queue and pops it on handshake.
// -----------------------------------------------------------------------------
module tb_freq_gate_ctrl;

    localparam int G = 10;
    localparam int S = 2;
    localparam int W = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic start = 1'b0;
    logic cont  = 1'b0;
    logic busy;

    freq_gate_ctrl_if #(.CNT_W(W)) meas_if();

    freq_gate_ctrl #(
        .GATE_CYCLES   (G),
        .SETTLE_CYCLES (S),
        .CNT_W         (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .cont  (cont),
        .busy  (busy),
        .meas  (meas_if)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;   // number of rising edges seen outside reset
    int en_count  = 0;
    int n_results = 0;
    int clr_q[$];

    // ---------------- reference model state ----------------
    bit           m_active  = 1'b0;  // measurement between accept and capture
    bit           m_pending = 1'b0;  // captured result awaiting handshake
    int           m_t0      = 0;     // accept edge of the current measurement
    logic [W:0]   sb_q[$];           // {ovf, data} expected results

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active  = 1'b0;
                m_pending = 1'b0;
                sb_q.delete();
            end else begin
                cyc++;
                if (m_pending) begin
                    if (meas_if.res_ready) begin
                        m_pending = 1'b0;
                        if (ena && cont) begin
                            m_active = 1'b1;
                            m_t0     = cyc;
                        end
                    end
                end else if (m_active) begin
                    if (!ena) begin
                        m_active = 1'b0;
                    end else if (cyc == m_t0 + G + S + 1) begin
                        sb_q.push_back({meas_if.cnt_ovf, meas_if.cnt_value});
                        m_pending = 1'b1;
                        m_active  = 1'b0;
                    end
                end else if (ena && (start || cont)) begin
                    m_active = 1'b1;
                    m_t0     = cyc;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check("cnt_clr",   {31'd0, meas_if.cnt_clr},
                  {31'd0, (m_active && (cyc == m_t0))});
            check("cnt_en",    {31'd0, meas_if.cnt_en},
                  {31'd0, (m_active && (cyc - m_t0 >= 1) && (cyc - m_t0 <= G))});
            check("res_valid", {31'd0, meas_if.res_valid}, {31'd0, m_pending});
            check("busy",      {31'd0, busy}, {31'd0, (m_active || m_pending)});
            if (meas_if.cnt_en)  en_count++;
            if (meas_if.cnt_clr) clr_q.push_back(cyc);
            if (meas_if.res_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_result_expected", 32'd0, 32'd1);
                end else begin
                    check("sb_res_data", {8'd0, meas_if.res_data}, {8'd0, sb_q[0][W-1:0]});
                    check("sb_res_ovf",  {31'd0, meas_if.res_ovf}, {31'd0, sb_q[0][W]});
                    if (meas_if.res_ready) begin
                        void'(sb_q.pop_front());
                        n_results++;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_valid(input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            #2;
            if (meas_if.res_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            #2;
            if (!busy) seen = 1'b1;
        end
        check({tag, "_idle_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_gate(input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            #2;
            if (meas_if.cnt_en) seen = 1'b1;
        end
        check({tag, "_gate_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cnt_clr"},   {31'd0, meas_if.cnt_clr},   32'd0);
        check({tag, "_cnt_en"},    {31'd0, meas_if.cnt_en},    32'd0);
        check({tag, "_res_data"},  {8'd0,  meas_if.res_data},  32'd0);
        check({tag, "_res_ovf"},   {31'd0, meas_if.res_ovf},   32'd0);
        check({tag, "_res_valid"}, {31'd0, meas_if.res_valid}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},              32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_acc;
        int clr_before;
        int en_before;

        meas_if.res_ready = 1'b0;
        meas_if.cnt_value = '0;
        meas_if.cnt_ovf   = 1'b0;

        // Reset state
        #2;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single shot with backpressure
        @(negedge clk);
        ena               = 1'b1;
        start             = 1'b1;
        meas_if.cnt_value = 24'd12345;
        en_count          = 0;
        t_acc             = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(40, "single");
        check("single_latency", cyc - t_acc, G + S + 1);
        check("single_en_cycles", en_count, G);
        check("single_res_data", {8'd0, meas_if.res_data}, 32'd12345);
        check("single_res_ovf", {31'd0, meas_if.res_ovf}, 32'd0);
        clr_before = clr_q.size();
        en_before  = en_count;
        @(negedge clk);
        meas_if.cnt_value = 24'd999;
        start             = 1'b1;   // must be ignored outside IDLE
        repeat (20) @(negedge clk);
        start = 1'b0;
        #2;
        check("bp_res_data", {8'd0, meas_if.res_data}, 32'd12345);
        check("bp_no_clr", clr_q.size(), clr_before);
        check("bp_no_en", en_count, en_before);
        @(negedge clk);
        meas_if.res_ready = 1'b1;
        @(negedge clk);
        meas_if.res_ready = 1'b0;
        #2;
        check("hs_valid_low", {31'd0, meas_if.res_valid}, 32'd0);
        check("hs_busy_low", {31'd0, busy}, 32'd0);
        check("hs_data_kept", {8'd0, meas_if.res_data}, 32'd12345);

        // Continuous mode
        clr_q.delete();
        n_results = 0;
        @(negedge clk);
        cont              = 1'b1;
        meas_if.res_ready = 1'b1;
        for (int i = 0; i < 120 && n_results < 5; i++) begin
            @(negedge clk);
            meas_if.cnt_value = W'($urandom);
        end
        cont = 1'b0;
        check("cont_results", {31'd0, (n_results >= 5)}, 32'd1);
        wait_idle(40, "cont");
        for (int i = 1; i < 5 && i < clr_q.size(); i++) begin
            check("cont_clr_period", clr_q[i] - clr_q[i-1], G + S + 2);
        end

        // Abort in GATE cycle 5, then a full gate
        for (int n = 0, i = 0; i < 30 && n < 5; i++) begin
            if (i == 0) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            @(negedge clk);
            #2;
            if (meas_if.cnt_en) n++;
        end
        ena = 1'b0;
        @(posedge clk);
        #1;
        check("abort_en_low", {31'd0, meas_if.cnt_en}, 32'd0);
        check("abort_busy_low", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        ena      = 1'b1;
        en_count = 0;
        pulse_start();
        wait_idle(40, "abort_rerun");
        check("abort_rerun_en_cycles", en_count, G);

        // Overflow capture
        @(negedge clk);
        meas_if.res_ready = 1'b0;
        meas_if.cnt_value = 24'hFFFFFF;
        meas_if.cnt_ovf   = 1'b1;
        pulse_start();
        wait_valid(40, "ovf");
        check("ovf_res_ovf", {31'd0, meas_if.res_ovf}, 32'd1);
        check("ovf_res_data", {8'd0, meas_if.res_data}, 32'h00FFFFFF);
        @(negedge clk);
        meas_if.res_ready = 1'b1;
        meas_if.cnt_ovf   = 1'b0;
        wait_idle(10, "ovf");

        // Async reset mid-GATE
        pulse_start();
        wait_gate(10, "rst_gate");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_gate");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("rst_gate_quiet", {31'd0, busy}, 32'd0);

        // Async reset mid-PRESENT
        meas_if.res_ready = 1'b0;
        meas_if.cnt_value = 24'h00ABCD;
        pulse_start();
        wait_valid(40, "rst_present");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_present");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("rst_present_quiet", {31'd0, busy}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            ena               = ($urandom_range(0, 19) != 0);
            start             = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 49) == 0) cont = ~cont;
            meas_if.res_ready = ($urandom_range(0, 1) == 1);
            meas_if.cnt_value = W'($urandom);
            meas_if.cnt_ovf   = ($urandom_range(0, 9) == 0);
        end

        // Drain
        @(negedge clk);
        ena               = 1'b1;
        start             = 1'b0;
        cont              = 1'b0;
        meas_if.res_ready = 1'b1;
        wait_idle(40, "drain");
        repeat (2) @(negedge clk);
        check("drain_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
Measurement sequencer for the frequency counter datapath. Opens a fixed-length gate window on the edge counter: it clears the counter, enables it for GATE_CYCLES clocks, waits for in-flight synchronised edges to land, then captures the count. The captured result goes to the OLED display formatter over a valid/ready handshake. Supports single-shot (start pulse) and continuous re-arming modes.

Parameters:
GATE_CYCLES, 1000, gate window length in clk cycles; must be >= 1
SETTLE_CYCLES, 2, post-gate wait in cycles covering input synchroniser latency; must be >= 1
CNT_W, 24, counter/result width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; low aborts a measurement
start  in  1  single-shot trigger, sampled only in IDLE
cont  in  1  continuous mode: re-arm automatically
cnt_value  in  CNT_W  live count from the edge counter
cnt_ovf  in  1  counter saturated/wrapped flag from the edge counter
cnt_clr  out  1  synchronous clear to the edge counter
cnt_en  out  1  count enable (gate open)
res_data  out  CNT_W  captured count
res_ovf  out  1  captured overflow flag
res_valid  out  1  result available
res_ready  in  1  display formatter accepts result
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset forces state=IDLE, timer=0, and all outputs to 0 (cnt_clr, cnt_en, res_data, res_ovf, res_valid, busy) immediately, without waiting for a clock edge.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States:
  - IDLE: If ena && (start || cont) at an edge, go to CLEAR. start is ignored when ena is low and in every non-IDLE state.
  - CLEAR: Exactly 1 cycle; cnt_clr=1, cnt_en=0. Load timer = GATE_CYCLES-1, then go to GATE.
  - GATE: cnt_en=1. Timer decrements each cycle. When timer==0, load timer = SETTLE_CYCLES-1 and go to SETTLE. cnt_en is high for exactly GATE_CYCLES cycles.
  - SETTLE: cnt_en=0. Timer decrements. At timer==0, capture res_data<=cnt_value and res_ovf<=cnt_ovf, set res_valid, and go to PRESENT.
  - PRESENT: res_valid=1; res_data and res_ovf are held stable. On an edge with res_ready=1, clear res_valid. Then go to CLEAR if ena && cont, else IDLE. res_data keeps its last value after the handshake.
- Latency: start accepted at edge E → CLEAR in cycle after E → cnt_en high after edges E+1..E+GATE_CYCLES → res_valid high after edge E+GATE_CYCLES+SETTLE_CYCLES+1.
- Continuous period with res_ready tied high is GATE_CYCLES+SETTLE_CYCLES+2 cycles, measured cnt_clr to cnt_clr.
- Abort: ena low at an edge while in CLEAR, GATE or SETTLE → next state is IDLE, cnt_en/cnt_clr drop, and no result is produced; res_valid stays 0.
- ena low in PRESENT does not drop res_valid, because the handshake must complete. After acceptance the block goes to IDLE.
- Backpressure: while res_valid && !res_ready, no new gate starts and cnt_en stays 0.
- cont may change at any time; it is only evaluated in IDLE and at PRESENT exit.
- Timer width is clog2(max(GATE_CYCLES,SETTLE_CYCLES))+1. The timer never wraps.

Test Plan:
- Single shot (GATE=10, SETTLE=2): ena=1, start pulse at edge 0, cnt_value=12345 → cnt_clr high 1 cycle after edge 0; cnt_en high exactly 10 cycles; res_valid rises after edge 13 with res_data=12345, res_ovf=0; busy low after handshake.
- Backpressure: same stimulus, res_ready low for 20 cycles after valid, cnt_value changed to 999 → res_data stays 12345, no cnt_clr/cnt_en activity; one-cycle res_ready → res_valid=0 next cycle, state IDLE.
- Continuous: cont=1, res_ready=1 → cnt_clr pulses every 14 cycles; check 5 consecutive results, each capturing the value driven at its capture edge.
- Abort: ena dropped at GATE cycle 5 → cnt_en=0 next cycle, busy=0, res_valid never asserts; a later start runs a full 10-cycle gate.
- Overflow: cnt_ovf=1, cnt_value=24'hFFFFFF at the capture edge → res_ovf=1, res_data=24'hFFFFFF.
- Async reset: rst_n pulled low mid-GATE and mid-PRESENT, between clock edges → all outputs 0 immediately; after release, no activity until start.
